// File: rtl/j_upcntn.sv
// j_upcntn: loadable counter with wrap/saturate modes, cascade carry-out and a wrap pulse.
// Optional macro J_UPCNTN_DOWN_EN builds the down-count path; without it dn is ignored.
module j_upcntn #(
    parameter int          WIDTH  = 16,
    parameter int unsigned RSTVAL = 0
) (
    input  logic             sys_clk,
    input  logic             resl,
    input  logic             ci,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             dn,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             wrp
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RSTVAL);

    logic down;
    logic at_edge;

`ifdef J_UPCNTN_DOWN_EN
    assign down = dn;
`else
    logic unused_dn;
    assign unused_dn = dn;
    assign down      = 1'b0;
`endif

    // at_edge: the next step in the current direction would cross the range boundary
    assign at_edge = down ? (q == '0) : (q == '1);
    assign co      = ci & at_edge;

    function automatic logic [WIDTH-1:0] step_q(
        input logic [WIDTH-1:0] v,
        input logic             down_i,
        input logic             edge_i,
        input logic             sat_i
    );
        if (edge_i && sat_i)
            return v;
        return down_i ? (v - WIDTH'(1)) : (v + WIDTH'(1));
    endfunction

    always_ff @(posedge sys_clk or negedge resl) begin
        if (!resl) begin
            q   <= RST_Q;
            wrp <= 1'b0;
        end else if (ld) begin
            q   <= d;
            wrp <= 1'b0;
        end else if (ci) begin
            q   <= step_q(q, down, at_edge, sat);
            wrp <= at_edge & ~sat;
        end else begin
            wrp <= 1'b0;
        end
    end

endmodule

// File: tb/tb_j_upcntn.sv
// Bench for j_upcntn: directed scenarios plus randomized steps against an integer model.
module tb_j_upcntn;

`ifdef J_UPCNTN_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resl;
    logic       ci, ld, dn, sat;
    logic [3:0] d;
    logic [3:0] q;
    logic       co, wrp;

    logic       resl3, ci3, ld3;
    logic [3:0] d3, q3;
    logic       co3, wrp3;

    logic       ci_c;
    logic [3:0] q_lo, q_hi;
    logic       co_lo, co_hi, wrp_lo, wrp_hi;

    logic       ci1;
    logic [0:0] q1;
    logic       co1, wrp1;

    logic       zero = 1'b0;
    logic [3:0] zero4 = 4'd0;
    logic [0:0] zero1 = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int mq       = 0;
    bit mwrp     = 1'b0;

    always #5 clk = ~clk;

    j_upcntn #(.WIDTH(4), .RSTVAL(0)) u_dut (
        .sys_clk(clk), .resl(resl), .ci(ci), .ld(ld), .d(d), .dn(dn), .sat(sat),
        .q(q), .co(co), .wrp(wrp)
    );

    j_upcntn #(.WIDTH(4), .RSTVAL(3)) u_r3 (
        .sys_clk(clk), .resl(resl3), .ci(ci3), .ld(ld3), .d(d3), .dn(zero), .sat(zero),
        .q(q3), .co(co3), .wrp(wrp3)
    );

    j_upcntn #(.WIDTH(4), .RSTVAL(0)) u_lo (
        .sys_clk(clk), .resl(resl), .ci(ci_c), .ld(zero), .d(zero4), .dn(zero), .sat(zero),
        .q(q_lo), .co(co_lo), .wrp(wrp_lo)
    );

    j_upcntn #(.WIDTH(4), .RSTVAL(0)) u_hi (
        .sys_clk(clk), .resl(resl), .ci(co_lo), .ld(zero), .d(zero4), .dn(zero), .sat(zero),
        .q(q_hi), .co(co_hi), .wrp(wrp_hi)
    );

    j_upcntn #(.WIDTH(1), .RSTVAL(0)) u_w1 (
        .sys_clk(clk), .resl(resl), .ci(ci1), .ld(zero), .d(zero1), .dn(zero), .sat(zero),
        .q(q1), .co(co1), .wrp(wrp1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the main counter: drive, check co mid-cycle, then q/wrp after the edge.
    task automatic cyc(input bit ld_i, input logic [3:0] d_i, input bit ci_i,
                       input bit dn_i, input bit sat_i);
        bit down;
        bit exp_co;
        int nq;
        ld = ld_i; d = d_i; ci = ci_i; dn = dn_i; sat = sat_i;
        down   = DOWN_EN && dn_i;
        exp_co = ci_i && (down ? (mq == 0) : (mq == 15));
        #4;
        chk("co", 32'(co), 32'(exp_co));
        @(posedge clk); #1;
        if (ld_i) begin
            mq   = int'(d_i);
            mwrp = 1'b0;
        end else if (ci_i) begin
            nq = down ? mq - 1 : mq + 1;
            if (nq < 0 || nq > 15) begin
                if (sat_i) mwrp = 1'b0;
                else begin
                    mq   = (nq + 16) % 16;
                    mwrp = 1'b1;
                end
            end else begin
                mq   = nq;
                mwrp = 1'b0;
            end
        end else begin
            mwrp = 1'b0;
        end
        chk("q", 32'(q), 32'(mq));
        chk("wrp", 32'(wrp), 32'(mwrp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resl = 1'b0; ci = 0; ld = 0; dn = 0; sat = 0; d = 4'd0;
        resl3 = 1'b0; ci3 = 0; ld3 = 0; d3 = 4'd0;
        ci_c = 0; ci1 = 0;
        #12;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_wrp", 32'(wrp), 32'd0);
        chk("rst_q3", 32'(q3), 32'd3);
        chk("rst_cascade", 32'({q_hi, q_lo}), 32'd0);
        resl = 1'b1; resl3 = 1'b1;
        @(posedge clk); #1;

        // Full up-count wrap from reset
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            chk("r26_q", 32'(q), 32'((i + 1) % 16));
            chk("r26_wrp", 32'(wrp), 32'(i == 15));
        end
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("r26_post_q", 32'(q), 32'd1);
        chk("r26_post_wrp", 32'(wrp), 32'd0);

        // Saturating up count
        cyc(1'b1, 4'd14, 1'b0, 1'b0, 1'b1);
        chk("r27_ld", 32'(q), 32'd14);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
            chk("r27_q", 32'(q), 32'd15);
            chk("r27_wrp", 32'(wrp), 32'd0);
            chk("r27_co", 32'(co), 32'd1);
        end

        // Load at the boundary with ci high: no wrap pulse, co still reflects q
        cyc(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("r19_q", 32'(q), 32'd0);
        chk("r19_wrp", 32'(wrp), 32'd0);

        // Down count through zero, or dn ignored when down counting is not built
        cyc(1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        if (DOWN_EN) begin
            chk("r28_q0", 32'(q), 32'd0);
            chk("r28_co", 32'(co), 32'd1);
            cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            chk("r28_q15", 32'(q), 32'd15);
            chk("r28_wrp", 32'(wrp), 32'd1);
        end else begin
            chk("r25_q", 32'(q), 32'd2);
            cyc(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            chk("r25_wrap_q", 32'(q), 32'd0);
            chk("r25_wrap_wrp", 32'(wrp), 32'd1);
        end

        // Load beats count enable
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("r29_q", 32'(q), 32'd9);
        chk("r29_wrp", 32'(wrp), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end
        ld = 0; ci = 0;

        // Single-bit toggle cell
        begin
            logic exp1;
            exp1 = 1'b0;
            ci1  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                #4;
                chk("w1_co", 32'(co1), 32'(exp1));
                @(posedge clk); #1;
                chk("w1_wrp", 32'(wrp1), 32'(exp1));
                exp1 = ~exp1;
                chk("w1_q", 32'(q1), 32'(exp1));
            end
            ci1 = 1'b0;
        end

        // Two cascaded 4-bit counters behave as one 8-bit counter
        ci_c = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            chk("r30_pair", 32'({q_hi, q_lo}), 32'((i + 1) % 256));
        end
        ci_c = 1'b0;

        // Asynchronous reset mid-cycle
        ld3 = 1'b1; d3 = 4'd7;
        @(posedge clk); #1;
        ld3 = 1'b0;
        chk("r31_ld", 32'(q3), 32'd7);
        #2;
        resl3 = 1'b0;
        #1;
        chk("r31_q", 32'(q3), 32'd3);
        chk("r31_wrp", 32'(wrp3), 32'd0);
        #1;
        resl3 = 1'b1;
        ci3 = 1'b1;
        @(posedge clk); #1;
        ci3 = 1'b0;
        chk("r23_first_step", 32'(q3), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/j_upcntn.md
J_UPCNTN -- requirements
Module: j_upcntn

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits (1..32).
REQ-002 SHALL have parameter RSTVAL, default 0, value loaded into q on reset.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resl, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ci, input, 1, count enable / carry-in; one step per cycle while high.
REQ-006 SHALL have port ld, input, 1, synchronous load strobe.
REQ-007 SHALL have port d, input, WIDTH, load data.
REQ-008 SHALL have port dn, input, 1, direction: 0 = up, 1 = down.
REQ-009 SHALL have port sat, input, 1, mode: 0 = wrap, 1 = saturate.
REQ-010 SHALL have port q, output, WIDTH, registered count.
REQ-011 SHALL have port co, output, 1, combinational carry-out for cascading.
REQ-012 SHALL have port wrp, output, 1, registered one-cycle wrap pulse.

Function
REQ-013 SHALL give ld priority over ci: ld=1 sets q <= d next edge, regardless of ci, dn and sat.
REQ-014 SHALL, with ld=0 and ci=1, step q <= q+1 (dn=0) or q-1 (dn=1), modulo 2^WIDTH.
REQ-015 SHALL hold q unchanged when ld=0 and ci=0.
REQ-016 SHALL drive co = ci & (q == all-ones) when dn=0 and co = ci & (q == 0) when dn=1, independent of sat and ld, so that chained instances behave as one wide counter.
REQ-017 SHALL, in wrap mode (sat=0), roll all-ones to 0 (up) and 0 to all-ones (down), and assert wrp for exactly the following cycle.
REQ-018 SHALL, in saturate mode (sat=1), hold q at all-ones (up) or 0 (down) when a step would cross the boundary, keep wrp low, and still drive co per REQ-016.
REQ-019 SHALL not assert wrp on a load, even if d equals a boundary value.
REQ-020 SHALL let a dn or sat change take effect for the step taken on the same edge.
REQ-021 SHALL, for WIDTH=1, behave as a single toggle cell: q ^= ci, with co = ci & q when dn=0.

Reset
REQ-022 SHALL, while resl=0, force q=RSTVAL and wrp=0 asynchronously; co then follows REQ-016 from q=RSTVAL.
REQ-023 SHALL take its first step or load on the first rising sys_clk edge after resl deasserts; a step in progress when reset asserts SHALL be discarded.

Configuration
REQ-024 SHALL honour macro J_UPCNTN_DOWN_EN: when defined, dn and the down-count behaviour are implemented as above.
REQ-025 SHALL, when J_UPCNTN_DOWN_EN is undefined, ignore dn (treat it as 0), count up only, and derive co and wrp from the up-count terms only; the dn port SHALL remain present.

Verification
REQ-026 SHALL verify WIDTH=4, sat=0, dn=0, ci=1 from reset: q steps 0..15; co=1 only while q=15; q wraps to 0; wrp=1 for the single cycle after the wrap.
REQ-027 SHALL verify WIDTH=4, sat=1, dn=0: ld d=14, then ci=1 for 3 cycles gives q=15,15,15 with wrp=0 and co=1 while q=15.
REQ-028 SHALL verify WIDTH=4, dn=1, sat=0: ld d=1, then ci=1 gives q=0 (co=1), then q=15 with wrp=1 the next cycle.
REQ-029 SHALL verify ld and ci high together with q=5 and d=9: q=9 next cycle, no step applied, wrp=0.
REQ-030 SHALL verify two WIDTH=4 instances cascaded through co->ci: with ci=1 for 256 cycles the pair counts 0x00..0xFF and returns to 0x00.
REQ-031 SHALL verify asynchronous reset: resl pulsed low mid-cycle with q=7 and RSTVAL=3 gives q=3 immediately, without a clock edge, and wrp=0.
